instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Front-end stage of the single-cycle core. Owns the program counter, fetches one 32-bit instruction per round trip over a valid/ready instruction-memory interface, and presents `instruction` plus `pcNext` to the execute datapath for exactly one cycle. After each instruction it updates the PC with one of three values: sequential PC+4, a JAL target, or an external redirect.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word aligned.

Ports (one clock `clk`; reset `reset` is synchronous and active-high):
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_addr`  out  32  fetch address (current PC).
- `imem_rsp_valid`  in  1  response data valid.
- `imem_rsp_data`  in  32  fetched instruction word.
- `redirect_valid`  in  1  external PC override (branch/trap).
- `redirect_target`  in  32  override target.
- `instruction`  out  32  instruction to execute datapath.
- `pcNext`  out  32  PC+4 of the presented instruction; the JAL link value.
- `pc`  out  32  PC of the presented instruction.
- `exec_valid`  out  1  one-cycle strobe; datapath commits register/memory writes only when high.
- `fault`  out  1  sticky misaligned-target fault.

## Operation
- States: IDLE, REQ, WAIT, EXEC, HALT.
- IDLE: entered on reset and held for one cycle. Next state: REQ.
- REQ:
  - `imem_req_valid`=1 and `imem_addr`=`pc`.
  - On `imem_req_valid & imem_req_ready`, go to WAIT. Otherwise hold; the address stays stable.
- WAIT:
  - On `imem_rsp_valid`, latch `imem_rsp_data` into `instruction` and go to EXEC.
  - `imem_rsp_valid` in any state other than WAIT is ignored.
- EXEC: `exec_valid`=1 for this cycle only. The next PC is chosen by priority:
  1. `redirect_valid` → `redirect_target`.
  2. Opcode 7'b1101111 (JAL) → `pc` + {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}.
  3. Otherwise → `pc`+4.
- Fault check on the chosen next PC:
  - Bits [1:0] ≠ 0 → `fault`=1, go to HALT. `pc` is not updated.
  - Otherwise load `pc` and go to REQ.
- HALT: absorbing state. No requests, `exec_valid`=0. Only `reset` exits.
- `pcNext` = `pc`+4 at all times.
- All additions are 32-bit and wrap modulo 2^32. PC 32'hFFFF_FFFC advances to 32'h0000_0000 with no fault.
- `redirect_valid` is sampled only in EXEC.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `pcNext`=`RESET_PC`+4.
  - `instruction`=32'h0000_0013 (NOP).
  - `exec_valid`=0, `imem_req_valid`=0, `fault`=0.
  - `imem_addr`=`RESET_PC`.
- Minimum latency with zero-wait memory (ready in REQ, response the cycle after): 3 cycles per instruction (REQ, WAIT, EXEC). The first EXEC occurs 4 cycles after reset deasserts, counting IDLE.
- `instruction`, `pc` and `pcNext` are registered and stable for the whole EXEC cycle. They hold their values outside EXEC.
- Handshake rules:
  - At most one request is outstanding.
  - Once `imem_req_valid` is asserted, it is not deasserted before it is accepted (except by `reset`).
- Reset in any state, including mid-WAIT: returns to IDLE next cycle with reset values.
  - The instruction memory shares `reset`, so no stale response can arrive after reset.

## Configuration
- `FETCH_JAL_REDIRECT_EN`:
  - Defined: JAL target computed in fetch, as in Operation priority 2.
  - Undefined: JAL treated as sequential (`pc`+4). JAL control flow must then come through `redirect_valid`. The adder and immediate decode are removed.

## Structure
- Package `fetch_pkg` holds:
  - State encoding enum.
  - `OPCODE_JAL` = 7'b1101111.
  - `NOP_INSTR` = 32'h0000_0013.
  - `PC_STEP` = 32'd4.
- One combinational sub-module, `fetch_next_pc`:
  - Inputs: `pc`, `instruction`, `redirect_valid`, `redirect_target`.
  - Outputs: the next PC and a misaligned flag.
  - Contains the priority mux and the JAL immediate decode.

## Test plan
- Reset with `RESET_PC`=0, zero-wait memory returning ADDI words: `imem_addr` sequence is 0, 4, 8; `exec_valid` pulses every 3rd cycle; `pcNext` in each EXEC is 4, 8, 12.
- `imem_req_ready` held low for 5 cycles: `imem_req_valid` stays high and `imem_addr` stays constant; no `exec_valid` until accepted.
- JAL at PC 0x100 with offset +0x20 (macro defined): next `imem_addr`=0x120 and `pcNext` during EXEC=0x104. With the macro undefined, next `imem_addr`=0x104.
- `redirect_valid`=1 with target 0x200 during EXEC of a JAL: next `imem_addr`=0x200, because redirect wins.
- Redirect target 0x202: `fault`=1, state HALT, no further requests, `pc` unchanged; `reset` clears all.
- PC 0xFFFF_FFFC with sequential instruction: next `imem_addr`=0x0, `fault`=0. Reset asserted mid-WAIT: reset values appear the next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional JAL target generation is enabled by FETCH_JAL_REDIRECT_EN.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        EXEC,
        HALT
    } fetch_state_t;

    localparam logic [6:0]  OPCODE_JAL = 7'b1101111;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] PC_STEP    = 32'd4;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response channel of the fetch stage.
// The master side issues addresses, the slave side returns words.
interface instruction_fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC selection: redirect, then JAL (FETCH_JAL_REDIRECT_EN), then PC+4.
// Also flags a next PC that is not word aligned.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

`ifdef FETCH_JAL_REDIRECT_EN
    logic [31:0] jal_imm;
    logic        is_jal;
    logic [4:0]  unused_rd;

    assign jal_imm = {{12{instruction[31]}},
                      instruction[19:12],
                      instruction[20],
                      instruction[30:21],
                      1'b0};
    assign is_jal    = (instruction[6:0] == OPCODE_JAL);
    assign unused_rd = instruction[11:7];

    always_comb begin
        next_pc = pc + PC_STEP;
        if (redirect_valid) begin
            next_pc = redirect_target;
        end else if (is_jal) begin
            next_pc = pc + jal_imm;
        end
    end
`else
    logic unused_instr;

    // Without in-fetch JAL the word is only needed by the datapath.
    assign unused_instr = ^instruction;

    always_comb begin
        next_pc = pc + PC_STEP;
        if (redirect_valid) begin
            next_pc = redirect_target;
        end
    end
`endif

    assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/instruction_fetch.sv
// Front-end fetch stage: owns the PC, one outstanding imem request.
// Build option FETCH_JAL_REDIRECT_EN computes JAL targets locally.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_fetch_if.master        imem,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_target,
    output logic [31:0]                instruction,
    output logic [31:0]                pcNext,
    output logic [31:0]                pc,
    output logic                       exec_valid,
    output logic                       fault
);

    fetch_state_t state;
    logic         req_valid;
    logic [31:0]  next_pc;
    logic         misaligned;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_addr      = pc;

    fetch_next_pc u_next_pc (
        .pc              (pc),
        .instruction     (instruction),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .next_pc         (next_pc),
        .misaligned      (misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            pcNext      <= RESET_PC + PC_STEP;
            instruction <= NOP_INSTR;
            exec_valid  <= 1'b0;
            req_valid   <= 1'b0;
            fault       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    req_valid <= 1'b1;
                    state     <= REQ;
                end
                REQ: begin
                    if (imem.imem_req_ready) begin
                        req_valid <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        instruction <= imem.imem_rsp_data;
                        exec_valid  <= 1'b1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    exec_valid <= 1'b0;
                    // A bad target freezes the PC so the faulting one stays visible.
                    if (misaligned) begin
                        fault <= 1'b1;
                        state <= HALT;
                    end else begin
                        pc        <= next_pc;
                        pcNext    <= next_pc + PC_STEP;
                        req_valid <= 1'b1;
                        state     <= REQ;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch.
// Honours FETCH_JAL_REDIRECT_EN in its reference model.
module tb_instruction_fetch;

    localparam logic [31:0] RP = 32'h0000_0000;
`ifdef FETCH_JAL_REDIRECT_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        bit          is_jal;
        logic [31:0] off;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] instruction;
    logic [31:0] pcNext;
    logic [31:0] pc;
    logic        exec_valid;
    logic        fault;

    instruction_fetch_if imem ();

    instruction_fetch #(.RESET_PC(RP)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem            (imem),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instruction     (instruction),
        .pcNext          (pcNext),
        .pc              (pc),
        .exec_valid      (exec_valid),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int exec_count = 0;

    int ready_mode = 0;
    int rsp_min = 0;
    int rsp_max = 0;
    int redir_mode = 0;
    int instr_mode = 0;
    bit spurious_en = 1'b0;
    bit gap_chk = 1'b1;
    logic [31:0] redir_tgt = 32'h0;
    logic [31:0] jal_off = 32'h0;

    rec_t exp_q[$];
    bit   rst_q = 1'b1;
    bit   acc_seen = 1'b0;
    bit   pending = 1'b0;
    int   delay = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_jal(input logic [31:0] off,
                                            input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
    endfunction

    function automatic rec_t gen_instr();
        rec_t r;
        logic [31:0] w;
        logic [31:0] w2;
        int k;
        w  = $urandom;
        w2 = $urandom;
        if (instr_mode == 1) k = $urandom_range(0, 2);
        else if (instr_mode == 2) k = 0;
        else k = 1;
        if (k == 0) begin
            r.off    = (instr_mode == 2) ? jal_off
                                         : {{11{w2[20]}}, w2[20:2], 2'b00};
            r.data   = enc_jal(r.off, w[11:7]);
            r.is_jal = 1'b1;
        end else begin
            r.data   = {w[31:7], 7'b0010011};
            r.is_jal = 1'b0;
            r.off    = 32'h0;
        end
        return r;
    endfunction

    always @(posedge clk) rst_q <= reset;

    // Memory and redirect stimulus, driven just after each rising edge.
    always @(posedge clk) begin
        rec_t r;
        logic [31:0] w;
        #1;
        imem.imem_rsp_valid = 1'b0;
        if (rst_q) begin
            pending = 1'b0;
            imem.imem_req_ready = 1'b0;
            redirect_valid = 1'b0;
        end else begin
            if (acc_seen) begin
                pending = 1'b1;
                delay = $urandom_range(rsp_min, rsp_max);
            end
            if (pending) begin
                if (delay == 0) begin
                    r = gen_instr();
                    exp_q.push_back(r);
                    imem.imem_rsp_valid = 1'b1;
                    imem.imem_rsp_data  = r.data;
                    pending = 1'b0;
                end else begin
                    delay--;
                end
            end else if (spurious_en && $urandom_range(0, 7) == 0) begin
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rsp_data  = $urandom;
            end
            case (ready_mode)
                0: imem.imem_req_ready = 1'b1;
                1: imem.imem_req_ready = ($urandom_range(0, 3) != 0);
                default: imem.imem_req_ready = 1'b0;
            endcase
            w = $urandom;
            case (redir_mode)
                0: redirect_valid = 1'b0;
                1: begin
                    redirect_valid = ($urandom_range(0, 5) == 0);
                    redirect_target = ($urandom_range(0, 9) == 0)
                        ? 32'hFFFF_FFFC : {16'h0, w[15:2], 2'b00};
                end
                default: begin
                    redirect_valid = 1'b1;
                    redirect_target = redir_tgt;
                end
            endcase
        end
    end

    logic [31:0] m_pc = RP;
    bit          m_halted = 1'b0;
    int          cnt = 0;
    bit          prev_pend = 1'b0;
    bit          prev_exec = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    // Reference model and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        rec_t r;
        logic [31:0] nxt;
        acc_seen = !reset && imem.imem_req_valid && imem.imem_req_ready;
        if (rst_q) begin
            check("rst_pc", pc, RP);
            check("rst_pcnext", pcNext, RP + 32'd4);
            check("rst_instr", instruction, 32'h0000_0013);
            check("rst_exec", {31'b0, exec_valid}, 32'd0);
            check("rst_req", {31'b0, imem.imem_req_valid}, 32'd0);
            check("rst_fault", {31'b0, fault}, 32'd0);
            check("rst_addr", imem.imem_addr, RP);
            m_pc = RP;
            m_halted = 1'b0;
            exp_q.delete();
            cnt = 0;
            prev_pend = 1'b0;
            prev_exec = 1'b0;
        end else begin
            cnt++;
            if (m_halted) begin
                check("halt_fault", {31'b0, fault}, 32'd1);
                check("halt_req", {31'b0, imem.imem_req_valid}, 32'd0);
                check("halt_exec", {31'b0, exec_valid}, 32'd0);
                check("halt_pc", pc, m_pc);
            end else begin
                if (prev_pend) begin
                    check("req_held", {31'b0, imem.imem_req_valid}, 32'd1);
                    check("addr_held", imem.imem_addr, prev_addr);
                end
                if (imem.imem_req_valid && imem.imem_req_ready)
                    check("req_addr", imem.imem_addr, m_pc);
                if (exec_valid) begin
                    if (prev_exec) check("exec_pulse", 32'd2, 32'd1);
                    if (gap_chk) check("exec_gap", cnt, 32'd3);
                    cnt = 0;
                    if (exp_q.size() == 0) begin
                        check("exec_unexpected", 32'd1, 32'd0);
                    end else begin
                        r = exp_q.pop_front();
                        check("exec_instr", instruction, r.data);
                        check("exec_pc", pc, m_pc);
                        check("exec_pcnext", pcNext, m_pc + 32'd4);
                        check("exec_fault", {31'b0, fault}, 32'd0);
                        if (redirect_valid) nxt = redirect_target;
                        else if (JAL_EN && r.is_jal) nxt = m_pc + r.off;
                        else nxt = m_pc + 32'd4;
                        if (nxt[1:0] != 2'b00) m_halted = 1'b1;
                        else m_pc = nxt;
                    end
                    exec_count++;
                end
            end
            prev_pend = imem.imem_req_valid && !imem.imem_req_ready;
            prev_addr = imem.imem_addr;
            prev_exec = exec_valid;
        end
    end

    task automatic wait_execs(input int n, input int bound);
        int start;
        start = exec_count;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            #1;
            if (exec_count >= start + n) begin
                n_chk++;
                return;
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_execs: got %0d execs expected %0d",
                 exec_count - start, n);
    endtask

    initial begin
        logic [31:0] a0;
        logic [31:0] p0;
        bit found;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_execs(6, 100);

        // Hold off acceptance and watch the request stay put.
        gap_chk = 1'b0;
        ready_mode = 2;
        @(posedge clk);
        #2;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            #1;
            found = imem.imem_req_valid;
        end
        check("stall_req_seen", {31'b0, found}, 32'd1);
        a0 = imem.imem_addr;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("stall_req", {31'b0, imem.imem_req_valid}, 32'd1);
            check("stall_addr", imem.imem_addr, a0);
            check("stall_exec", {31'b0, exec_valid}, 32'd0);
        end
        ready_mode = 0;
        wait_execs(2, 50);

        ready_mode = 1;
        rsp_min = 0;
        rsp_max = 3;
        redir_mode = 1;
        instr_mode = 1;
        spurious_en = 1'b1;
        wait_execs(250, 20000);

        redir_mode = 2;
        redir_tgt = 32'h100;
        instr_mode = 0;
        wait_execs(1, 500);
        redir_mode = 0;
        instr_mode = 2;
        jal_off = 32'h20;
        wait_execs(1, 500);
        check("jal_pc", pc, 32'h100);
        check("jal_pcnext", pcNext, 32'h104);
        redir_mode = 2;
        redir_tgt = 32'h200;
        wait_execs(1, 500);
        check("after_jal_pc", pc, JAL_EN ? 32'h120 : 32'h104);
        redir_tgt = 32'hFFFF_FFFC;
        instr_mode = 0;
        wait_execs(1, 500);
        check("redir_wins_pc", pc, 32'h200);
        redir_mode = 0;
        wait_execs(1, 500);
        check("top_pc", pc, 32'hFFFF_FFFC);
        check("top_pcnext", pcNext, 32'h0);
        wait_execs(1, 500);
        check("wrap_pc", pc, 32'h0);
        check("wrap_fault", {31'b0, fault}, 32'd0);

        redir_mode = 2;
        redir_tgt = 32'h202;
        wait_execs(1, 500);
        p0 = pc;
        redir_mode = 0;
        repeat (10) @(negedge clk);
        #1;
        check("fault_set", {31'b0, fault}, 32'd1);
        check("fault_noreq", {31'b0, imem.imem_req_valid}, 32'd0);
        check("fault_pc", pc, p0);

        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        ready_mode = 0;
        rsp_min = 6;
        rsp_max = 6;
        spurious_en = 1'b0;
        #1 reset = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            found = imem.imem_req_valid && imem.imem_req_ready;
        end
        check("midwait_accept", {31'b0, found}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("midwait_pc", pc, RP);
        check("midwait_instr", instruction, 32'h0000_0013);
        check("midwait_req", {31'b0, imem.imem_req_valid}, 32'd0);
        check("midwait_fault", {31'b0, fault}, 32'd0);
        @(posedge clk);
        rsp_min = 0;
        rsp_max = 0;
        gap_chk = 1'b1;
        #1 reset = 1'b0;
        wait_execs(3, 100);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
